stack_proc_io_bridge: RTL and testbench

- Host-side peripheral at the other end of the stack processor's memory-mapped I/O port.
- Drives the processor's 8-bit input port and watches its 8-bit output port.
- Uses two-phase toggle handshakes on reserved bits, so stack-processor programs can exchange bytes with a valid/ready host stream without loss.
- Sits beside the processor on the same clock; each direction is buffered by a small FIFO.

---
 rtl/stack_proc_io_bridge.sv | 192 +++++++++++++++++++
 tb/tb_stack_proc_io_bridge.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_proc_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : stack_proc_io_bridge
//  Description : Host-side peripheral on the stack processor's memory-mapped
//                I/O port. Bytes from a valid/ready host stream are presented
//                on the processor input port using a two-phase toggle
//                (bit 7). The processor acknowledges them by echoing that
//                toggle in data_out bit 6. Bytes the processor publishes with
//                its own toggle (data_out bit 7) are queued for the host.
//                Each direction has a small FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_proc_io_bridge #(
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [6:0] host_in_data,
    input  logic       host_in_valid,
    output logic       host_in_ready,
    output logic [5:0] host_out_data,
    output logic       host_out_valid,
    input  logic       host_out_ready,
    output logic [7:0] proc_data_in,
    input  logic [7:0] proc_data_out,
    output logic       out_overflow,
    output logic       proto_err
);

    localparam int c_IN_AW  = $clog2(IN_DEPTH);
    localparam int c_OUT_AW = $clog2(OUT_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Inbound path: host -> FIFO -> processor input port
    // ------------------------------------------------------------------------
    logic [6:0]       r_in_mem [IN_DEPTH];
    logic [c_IN_AW:0] r_in_wptr;
    logic [c_IN_AW:0] r_in_rptr;
    logic             w_in_full;
    logic             w_in_empty;
    logic             w_in_push;
    logic             w_in_pop;
    logic [6:0]       w_in_head;

    state_t           r_state;
    logic             r_in_tog;
    logic [6:0]       r_payload;
    logic             r_proto_err;
    logic             w_ack;
    logic             w_ack_match;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_in_full  = (r_in_wptr[c_IN_AW] != r_in_rptr[c_IN_AW]) &&
                        (r_in_wptr[c_IN_AW-1:0] == r_in_rptr[c_IN_AW-1:0]);
    assign w_in_empty = (r_in_wptr == r_in_rptr);
    assign w_in_push  = host_in_valid && !w_in_full;
    assign w_in_head  = r_in_mem[r_in_rptr[c_IN_AW-1:0]];

    assign w_ack       = proc_data_out[6];
    assign w_ack_match = (w_ack == r_in_tog);

    // A new byte is taken whenever nothing is outstanding: either idle, or
    // the processor has just echoed the current toggle.
    assign w_in_pop = !w_in_empty &&
                      ((r_state == ST_IDLE) || w_ack_match);

    assign host_in_ready = !w_in_full;
    assign proc_data_in  = {r_in_tog, r_payload};
    assign proto_err     = r_proto_err;

    // Inbound storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_in_push) begin
            r_in_mem[r_in_wptr[c_IN_AW-1:0]] <= host_in_data;
        end
    end

    // Inbound FIFO pointers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_in_wptr <= '0;
            r_in_rptr <= '0;
        end else begin
            if (w_in_push) begin
                r_in_wptr <= r_in_wptr + 1'b1;
            end
            if (w_in_pop) begin
                r_in_rptr <= r_in_rptr + 1'b1;
            end
        end
    end

    // Presentation FSM: loads the payload, flips the toggle, waits for ack.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state     <= ST_IDLE;
            r_in_tog    <= 1'b0;
            r_payload   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            // An ack that moves while nothing is outstanding is a protocol
            // violation; it is flagged but the ack bit is left as-is.
            if ((r_state == ST_IDLE) && !w_ack_match) begin
                r_proto_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_in_pop) begin
                        r_payload <= w_in_head;
                        r_in_tog  <= ~r_in_tog;
                        r_state   <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (w_in_pop) begin
                        r_payload <= w_in_head;
                        r_in_tog  <= ~r_in_tog;
                    end else if (w_ack_match) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outbound path: processor output port -> FIFO -> host
    // ------------------------------------------------------------------------
    logic [5:0]        r_out_mem [OUT_DEPTH];
    logic [c_OUT_AW:0] r_out_wptr;
    logic [c_OUT_AW:0] r_out_rptr;
    logic              r_prev_out_tog;
    logic              r_out_overflow;
    logic              w_out_full;
    logic              w_out_empty;
    logic              w_out_event;
    logic              w_out_pop;
    logic              w_out_push;
    logic              w_out_drop;

    assign w_out_full  = (r_out_wptr[c_OUT_AW] != r_out_rptr[c_OUT_AW]) &&
                         (r_out_wptr[c_OUT_AW-1:0] == r_out_rptr[c_OUT_AW-1:0]);
    assign w_out_empty = (r_out_wptr == r_out_rptr);
    assign w_out_event = proc_data_out[7] ^ r_prev_out_tog;
    assign w_out_pop   = !w_out_empty && host_out_ready;
    // A same-cycle pop frees the slot, so a full FIFO can still accept.
    assign w_out_push  = w_out_event && (!w_out_full || w_out_pop);
    assign w_out_drop  = w_out_event && w_out_full && !w_out_pop;

    assign host_out_valid = !w_out_empty;
    assign host_out_data  = r_out_mem[r_out_rptr[c_OUT_AW-1:0]];
    assign out_overflow   = r_out_overflow;

    // Outbound storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_out_push) begin
            r_out_mem[r_out_wptr[c_OUT_AW-1:0]] <= proc_data_out[5:0];
        end
    end

    // Toggle tracking, outbound pointers and the sticky overflow flag.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_prev_out_tog <= 1'b0;
            r_out_wptr     <= '0;
            r_out_rptr     <= '0;
            r_out_overflow <= 1'b0;
        end else begin
            r_prev_out_tog <= proc_data_out[7];
            if (w_out_push) begin
                r_out_wptr <= r_out_wptr + 1'b1;
            end
            if (w_out_pop) begin
                r_out_rptr <= r_out_rptr + 1'b1;
            end
            if (w_out_drop) begin
                r_out_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stack_proc_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stack_proc_io_bridge
//  Description : Directed bench for stack_proc_io_bridge: vector table for
//                the single-cycle behaviour plus hand sequences for FIFO
//                full, overflow, protocol error and asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_proc_io_bridge;

    logic       clk;
    logic       rstN;
    logic [6:0] host_in_data;
    logic       host_in_valid;
    logic       host_in_ready;
    logic [5:0] host_out_data;
    logic       host_out_valid;
    logic       host_out_ready;
    logic [7:0] proc_data_in;
    logic [7:0] proc_data_out;
    logic       out_overflow;
    logic       proto_err;

    int checks = 0;
    int errors = 0;

    stack_proc_io_bridge #(
        .IN_DEPTH (4),
        .OUT_DEPTH(4)
    ) dut (
        .clk           (clk),
        .rstN          (rstN),
        .host_in_data  (host_in_data),
        .host_in_valid (host_in_valid),
        .host_in_ready (host_in_ready),
        .host_out_data (host_out_data),
        .host_out_valid(host_out_valid),
        .host_out_ready(host_out_ready),
        .proc_data_in  (proc_data_in),
        .proc_data_out (proc_data_out),
        .out_overflow  (out_overflow),
        .proto_err     (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;     // apply reset before this vector
        logic       vin;
        logic [6:0] din;
        logic       ordy;
        logic [7:0] pdo;
        logic [7:0] e_pdi;
        logic       e_irdy;
        logic       e_ovld;
        logic [5:0] e_odata;
        logic       e_perr;
    } vec_t;

    vec_t tab [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstN           = 1'b0;
        host_in_valid  = 1'b0;
        host_in_data   = '0;
        host_out_ready = 1'b0;
        proc_data_out  = '0;
        #1;
        chk("rst_pdi",   proc_data_in,   8'h00);
        chk("rst_irdy",  host_in_ready,  1'b1);
        chk("rst_ovld",  host_out_valid, 1'b0);
        chk("rst_ovf",   out_overflow,   1'b0);
        chk("rst_perr",  proto_err,      1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] drain_pdo [5];
        logic [7:0] drain_pdi [5];
        logic [7:0] ovf_pdo   [5];

        //          rst   vin   din    ordy  pdo    e_pdi  irdy  ovld  odata  perr
        // Back-to-back inbound with processor acks, then return to idle.
        tab[0]  = '{1'b1, 1'b1, 7'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 6'h00, 1'b0};
        tab[1]  = '{1'b0, 1'b1, 7'h02, 1'b0, 8'h00, 8'h81, 1'b1, 1'b0, 6'h00, 1'b0};
        tab[2]  = '{1'b0, 1'b1, 7'h03, 1'b0, 8'h00, 8'h81, 1'b1, 1'b0, 6'h00, 1'b0};
        tab[3]  = '{1'b0, 1'b0, 7'h00, 1'b0, 8'h40, 8'h02, 1'b1, 1'b0, 6'h00, 1'b0};
        tab[4]  = '{1'b0, 1'b0, 7'h00, 1'b0, 8'h40, 8'h02, 1'b1, 1'b0, 6'h00, 1'b0};
        tab[5]  = '{1'b0, 1'b0, 7'h00, 1'b0, 8'h00, 8'h83, 1'b1, 1'b0, 6'h00, 1'b0};
        tab[6]  = '{1'b0, 1'b0, 7'h00, 1'b0, 8'h00, 8'h83, 1'b1, 1'b0, 6'h00, 1'b0};
        tab[7]  = '{1'b0, 1'b0, 7'h00, 1'b0, 8'h40, 8'h83, 1'b1, 1'b0, 6'h00, 1'b0};
        tab[8]  = '{1'b0, 1'b0, 7'h00, 1'b0, 8'h40, 8'h83, 1'b1, 1'b0, 6'h00, 1'b0};
        tab[9]  = '{1'b0, 1'b1, 7'h15, 1'b0, 8'h40, 8'h83, 1'b1, 1'b0, 6'h00, 1'b0};
        tab[10] = '{1'b0, 1'b0, 7'h00, 1'b0, 8'h40, 8'h15, 1'b1, 1'b0, 6'h00, 1'b0};
        tab[11] = '{1'b0, 1'b0, 7'h00, 1'b0, 8'h00, 8'h15, 1'b1, 1'b0, 6'h00, 1'b0};
        // 0x15 presentation latency, then outbound 0xAA -> 0x2B -> no-toggle.
        tab[12] = '{1'b1, 1'b1, 7'h15, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 6'h00, 1'b0};
        tab[13] = '{1'b0, 1'b0, 7'h00, 1'b1, 8'h00, 8'h95, 1'b1, 1'b0, 6'h00, 1'b0};
        tab[14] = '{1'b0, 1'b0, 7'h00, 1'b1, 8'hAA, 8'h95, 1'b1, 1'b1, 6'h2A, 1'b0};
        tab[15] = '{1'b0, 1'b0, 7'h00, 1'b1, 8'h2B, 8'h95, 1'b1, 1'b1, 6'h2B, 1'b0};
        tab[16] = '{1'b0, 1'b0, 7'h00, 1'b1, 8'h15, 8'h95, 1'b1, 1'b0, 6'h00, 1'b0};
        tab[17] = '{1'b0, 1'b0, 7'h00, 1'b1, 8'h3F, 8'h95, 1'b1, 1'b0, 6'h00, 1'b0};

        drain_pdo = '{8'h00, 8'h40, 8'h00, 8'h40, 8'h40};
        drain_pdi = '{8'h93, 8'h14, 8'h95, 8'h95, 8'h95};
        ovf_pdo   = '{8'h81, 8'h02, 8'h83, 8'h04, 8'h85};

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 18; i++) begin
            if (tab[i].rst) begin
                do_reset();
            end
            host_in_valid  = tab[i].vin;
            host_in_data   = tab[i].din;
            host_out_ready = tab[i].ordy;
            proc_data_out  = tab[i].pdo;
            step();
            chk($sformatf("vec%0d_pdi", i),  proc_data_in,   tab[i].e_pdi);
            chk($sformatf("vec%0d_irdy", i), host_in_ready,  tab[i].e_irdy);
            chk($sformatf("vec%0d_ovld", i), host_out_valid, tab[i].e_ovld);
            if (tab[i].e_ovld) begin
                chk($sformatf("vec%0d_odata", i), host_out_data, tab[i].e_odata);
            end
            chk($sformatf("vec%0d_perr", i), proto_err, tab[i].e_perr);
        end

        // ---------------- inbound FIFO fill without ack ----------------
        do_reset();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fill%0d_irdy", i), host_in_ready, 1'b1);
            host_in_valid = 1'b1;
            host_in_data  = 7'(17 + i);
            step();
        end
        chk("full_irdy", host_in_ready, 1'b0);
        chk("full_pdi",  proc_data_in,  8'h91);
        // Offer a byte while full (must be refused) together with the ack.
        host_in_data  = 7'h7F;
        proc_data_out = 8'h40;
        step();
        host_in_valid = 1'b0;
        chk("unfull_irdy", host_in_ready, 1'b1);
        chk("unfull_pdi",  proc_data_in,  8'h12);
        for (int i = 0; i < 5; i++) begin
            proc_data_out = drain_pdo[i];
            step();
            chk($sformatf("drain%0d_pdi", i), proc_data_in, drain_pdi[i]);
        end
        chk("drain_perr", proto_err, 1'b0);

        // ---------------- outbound overflow and drain ----------------
        do_reset();
        for (int i = 0; i < 5; i++) begin
            proc_data_out = ovf_pdo[i];
            step();
            chk($sformatf("ovf%0d_flag", i), out_overflow, (i == 4) ? 1'b1 : 1'b0);
        end
        host_out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("odrain%0d_vld", k),  host_out_valid, 1'b1);
            chk($sformatf("odrain%0d_data", k), host_out_data,  6'(k));
            step();
        end
        chk("odrain_empty",  host_out_valid, 1'b0);
        chk("odrain_sticky", out_overflow,   1'b1);
        chk("odrain_perr",   proto_err,      1'b0);

        // ---------------- protocol error and async reset ----------------
        do_reset();
        proc_data_out = 8'h40;
        step();
        chk("perr_set", proto_err, 1'b1);
        proc_data_out = 8'h00;
        host_in_valid = 1'b1;
        host_in_data  = 7'h05;
        step();
        host_in_data  = 7'h06;
        step();
        host_in_valid = 1'b0;
        proc_data_out = 8'h80;
        step();
        chk("pend_pdi",    proc_data_in,   8'h85);
        chk("pend_ovld",   host_out_valid, 1'b1);
        chk("pend_perr",   proto_err,      1'b1);
        #2;
        rstN = 1'b0;
        #1;
        chk("arst_pdi",  proc_data_in,   8'h00);
        chk("arst_irdy", host_in_ready,  1'b1);
        chk("arst_ovld", host_out_valid, 1'b0);
        chk("arst_perr", proto_err,      1'b0);
        chk("arst_ovf",  out_overflow,   1'b0);
        proc_data_out = 8'h00;
        @(negedge clk);
        rstN = 1'b1;
        repeat (3) step();
        chk("post_pdi",  proc_data_in,   8'h00);
        chk("post_ovld", host_out_valid, 1'b0);
        chk("post_irdy", host_in_ready,  1'b1);
        chk("post_perr", proto_err,      1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
